// File: rtl/mold_retrans_req.sv
// Retransmission request generator: buffers detected sequence gaps in a small FIFO and
// emits them as paced, size-limited request chunks on a valid/ready interface.
module mold_retrans_req #(
    parameter int SEQ_NUM_W   = 64,
    parameter int SID_W       = 80,
    parameter int ML_W        = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int REQ_CNT_MAX = 64,
    parameter int REQ_GAP_CYC = 8
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 miss_v_i,
    input  logic [SID_W-1:0]     miss_sid_i,
    input  logic [SEQ_NUM_W-1:0] miss_seq_num_start_i,
    input  logic [SEQ_NUM_W-1:0] miss_seq_num_cnt_i,
    output logic                 req_v_o,
    input  logic                 req_ready_i,
    output logic [SID_W-1:0]     req_sid_o,
    output logic [SEQ_NUM_W-1:0] req_seq_num_o,
    output logic [ML_W-1:0]      req_msg_cnt_o,
    output logic                 drop_o,
    output logic [15:0]          drop_cnt_o
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int GAP_W = (REQ_GAP_CYC > 1) ? $clog2(REQ_GAP_CYC) : 1;
    localparam logic [SEQ_NUM_W-1:0] CNT_MAX  = SEQ_NUM_W'(REQ_CNT_MAX);
    localparam logic [GAP_W-1:0]     GAP_LOAD = GAP_W'((REQ_GAP_CYC > 0) ? REQ_GAP_CYC - 1 : 0);
    localparam logic [PTR_W:0]       OCC_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    function automatic logic [SEQ_NUM_W-1:0] chunk_of(input logic [SEQ_NUM_W-1:0] r);
        return (r < CNT_MAX) ? r : CNT_MAX;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [SID_W-1:0]     fifo_sid   [FIFO_DEPTH];
    logic [SEQ_NUM_W-1:0] fifo_start [FIFO_DEPTH];
    logic [SEQ_NUM_W-1:0] fifo_cnt   [FIFO_DEPTH];
    logic [PTR_W:0]       wr_ptr, rd_ptr;
    logic [PTR_W:0]       occ;
    logic                 full, empty, push_req, push, pop;

    state_t               state;
    logic [SID_W-1:0]     cur_sid;
    logic [SEQ_NUM_W-1:0] cur_seq, rem;
    logic [GAP_W-1:0]     gap_cnt;
    logic [SEQ_NUM_W-1:0] chunk, next_seq, next_rem, head_cnt;

    assign occ      = wr_ptr - rd_ptr;
    assign full     = (occ == OCC_FULL);
    assign empty    = (wr_ptr == rd_ptr);
    assign push_req = miss_v_i && (miss_seq_num_cnt_i != '0);
    assign pop      = (state == IDLE) && !empty;
    // A full FIFO still accepts when the head leaves in the same cycle
    assign push     = push_req && (!full || pop);
    assign drop_o   = push_req && full && !pop;

    assign head_cnt  = fifo_cnt[rd_ptr[PTR_W-1:0]];
    assign req_sid_o = cur_sid;

    always_comb begin
        chunk    = chunk_of(rem);
        next_seq = cur_seq + chunk;
        next_rem = rem - chunk;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_sid[wr_ptr[PTR_W-1:0]]   <= miss_sid_i;
            fifo_start[wr_ptr[PTR_W-1:0]] <= miss_seq_num_start_i;
            fifo_cnt[wr_ptr[PTR_W-1:0]]   <= miss_seq_num_cnt_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            drop_cnt_o <= '0;
        end else begin
            if (push)   wr_ptr     <= wr_ptr + 1'b1;
            if (pop)    rd_ptr     <= rd_ptr + 1'b1;
            if (drop_o) drop_cnt_o <= sat_inc(drop_cnt_o);
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state         <= IDLE;
            req_v_o       <= 1'b0;
            req_seq_num_o <= '0;
            req_msg_cnt_o <= '0;
            cur_sid       <= '0;
            cur_seq       <= '0;
            rem           <= '0;
            gap_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        cur_sid       <= fifo_sid[rd_ptr[PTR_W-1:0]];
                        cur_seq       <= fifo_start[rd_ptr[PTR_W-1:0]];
                        rem           <= head_cnt;
                        req_seq_num_o <= fifo_start[rd_ptr[PTR_W-1:0]];
                        req_msg_cnt_o <= ML_W'(chunk_of(head_cnt));
                        req_v_o       <= 1'b1;
                        state         <= SEND;
                    end
                end
                SEND: begin
                    if (req_ready_i) begin
                        cur_seq <= next_seq;
                        rem     <= next_rem;
                        if (REQ_GAP_CYC > 0) begin
                            gap_cnt <= GAP_LOAD;
                            req_v_o <= 1'b0;
                            state   <= GAP;
                        end else if (next_rem != '0) begin
                            req_seq_num_o <= next_seq;
                            req_msg_cnt_o <= ML_W'(chunk_of(next_rem));
                        end else begin
                            req_v_o <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        if (rem != '0) begin
                            req_seq_num_o <= cur_seq;
                            req_msg_cnt_o <= ML_W'(chunk);
                            req_v_o       <= 1'b1;
                            state         <= SEND;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mold_retrans_req.sv
// Directed bench for mold_retrans_req: expected request chunks are queued when gaps are
// driven and checked against the request port by a monitor on the falling edge.
module tb_mold_retrans_req;
    localparam int SEQ_NUM_W   = 64;
    localparam int SID_W       = 80;
    localparam int ML_W        = 16;
    localparam int FIFO_DEPTH  = 4;
    localparam int REQ_CNT_MAX = 64;
    localparam int REQ_GAP_CYC = 8;

    typedef struct packed {
        logic [SID_W-1:0]     sid;
        logic [SEQ_NUM_W-1:0] seq;
        logic [ML_W-1:0]      cnt;
    } req_t;

    logic                 clk = 1'b0;
    logic                 nreset;
    logic                 miss_v_i;
    logic [SID_W-1:0]     miss_sid_i;
    logic [SEQ_NUM_W-1:0] miss_seq_num_start_i;
    logic [SEQ_NUM_W-1:0] miss_seq_num_cnt_i;
    logic                 req_v_o;
    logic                 req_ready_i;
    logic [SID_W-1:0]     req_sid_o;
    logic [SEQ_NUM_W-1:0] req_seq_num_o;
    logic [ML_W-1:0]      req_msg_cnt_o;
    logic                 drop_o;
    logic [15:0]          drop_cnt_o;

    req_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   since = 1000;

    mold_retrans_req #(
        .SEQ_NUM_W(SEQ_NUM_W), .SID_W(SID_W), .ML_W(ML_W), .FIFO_DEPTH(FIFO_DEPTH),
        .REQ_CNT_MAX(REQ_CNT_MAX), .REQ_GAP_CYC(REQ_GAP_CYC)
    ) dut (
        .clk(clk), .nreset(nreset),
        .miss_v_i(miss_v_i), .miss_sid_i(miss_sid_i),
        .miss_seq_num_start_i(miss_seq_num_start_i), .miss_seq_num_cnt_i(miss_seq_num_cnt_i),
        .req_v_o(req_v_o), .req_ready_i(req_ready_i), .req_sid_o(req_sid_o),
        .req_seq_num_o(req_seq_num_o), .req_msg_cnt_o(req_msg_cnt_o),
        .drop_o(drop_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one gap for a cycle; queue its chunks unless it is expected to be dropped.
    task automatic push(input logic [SID_W-1:0] sid, input logic [SEQ_NUM_W-1:0] start,
                        input logic [SEQ_NUM_W-1:0] cnt, input logic exp_drop);
        logic [SEQ_NUM_W-1:0] s, r, c;
        miss_v_i             = 1'b1;
        miss_sid_i           = sid;
        miss_seq_num_start_i = start;
        miss_seq_num_cnt_i   = cnt;
        if (!exp_drop) begin
            s = start;
            r = cnt;
            while (r != 0) begin
                c = (r > REQ_CNT_MAX) ? SEQ_NUM_W'(REQ_CNT_MAX) : r;
                exp_q.push_back('{sid: sid, seq: s, cnt: ML_W'(c)});
                s = s + c;
                r = r - c;
            end
        end
        #1;
        check("drop_o", drop_o, exp_drop);
        tick();
        miss_v_i = 1'b0;
    endtask

    task automatic wait_drain(input int max, input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < max) begin
            tick();
            n++;
        end
        check(tag, exp_q.size(), 0);
        repeat (REQ_GAP_CYC + 3) tick();
    endtask

    // Scoreboard monitor: every valid cycle must show the head of the expected queue.
    always @(negedge clk) begin
        if (!nreset) begin
            since = 1000;
        end else begin
            if (since < 1000) since++;
            if (req_v_o) begin
                check("spacing", since > REQ_GAP_CYC, 1'b1);
                if (exp_q.size() == 0) begin
                    check("unexpected_req", req_v_o, 1'b0);
                end else begin
                    check("req_sid", req_sid_o, exp_q[0].sid);
                    check("req_seq", req_seq_num_o, exp_q[0].seq);
                    check("req_cnt", req_msg_cnt_o, exp_q[0].cnt);
                    if (req_ready_i) begin
                        void'(exp_q.pop_front());
                        since = 0;
                    end
                end
            end
        end
    end

    initial begin
        nreset = 1'b0;
        req_ready_i = 1'b0;
        miss_v_i = 1'b0;
        miss_sid_i = '0;
        miss_seq_num_start_i = '0;
        miss_seq_num_cnt_i = '0;
        repeat (3) tick();
        check("rst_v", req_v_o, 1'b0);
        check("rst_sid", req_sid_o, 0);
        check("rst_seq", req_seq_num_o, 0);
        check("rst_cnt", req_msg_cnt_o, 0);
        check("rst_drop", drop_o, 1'b0);
        check("rst_drop_cnt", drop_cnt_o, 0);
        nreset = 1'b1;
        tick();

        // Single small gap: latency t+2, valid for exactly one cycle
        req_ready_i = 1'b1;
        push(80'd5, 64'd100, 64'd3, 1'b0);
        check("lat_t1", req_v_o, 1'b0);
        tick();
        check("lat_t2", req_v_o, 1'b1);
        tick();
        check("one_cycle", req_v_o, 1'b0);
        repeat (12) tick();
        check("single_done", exp_q.size(), 0);

        // Split into 64/64/22 with pacing
        push(80'd7, 64'd1000, 64'd150, 1'b0);
        wait_drain(200, "split_drain");
        check("split_idle", req_v_o, 1'b0);

        // Backpressure: fields held for 20 cycles, then a single transfer
        req_ready_i = 1'b0;
        push(80'd9, 64'd5000, 64'd10, 1'b0);
        tick();
        repeat (20) tick();
        check("bp_hold_v", req_v_o, 1'b1);
        check("bp_pending", exp_q.size(), 1);
        req_ready_i = 1'b1;
        tick();
        check("bp_single", req_v_o, 1'b0);
        check("bp_xfer", exp_q.size(), 0);
        repeat (12) tick();

        // Overflow: stalled downstream, five kept, sixth dropped, cnt=0 ignored
        req_ready_i = 1'b0;
        for (int k = 0; k < 5; k++)
            push(80'(11 + k), 64'(100 * (k + 1)), 64'd2, 1'b0);
        push(80'd16, 64'd600, 64'd2, 1'b1);
        push(80'd17, 64'd700, 64'd0, 1'b0);
        check("ovf_drop_cnt", drop_cnt_o, 1);
        // One transfer; after the pacing gap the FSM pops while a push lands on the full FIFO
        req_ready_i = 1'b1;
        tick();
        req_ready_i = 1'b0;
        repeat (REQ_GAP_CYC) tick();
        push(80'd18, 64'd800, 64'd2, 1'b0);
        check("pushpop_drop_cnt", drop_cnt_o, 1);
        req_ready_i = 1'b1;
        wait_drain(300, "ovf_drain");

        // Sequence number wrap across chunk boundary
        push(80'd21, 64'hFFFF_FFFF_FFFF_FFFE, 64'd150, 1'b0);
        wait_drain(200, "wrap_drain");

        // Reset while waiting between chunks
        push(80'd30, 64'd500, 64'd200, 1'b0);
        tick();
        check("rst_pre_v", req_v_o, 1'b1);
        tick();
        check("rst_in_gap", req_v_o, 1'b0);
        nreset = 1'b0;
        exp_q.delete();
        tick();
        check("rst_mid_v", req_v_o, 1'b0);
        check("rst_mid_drop_cnt", drop_cnt_o, 0);
        check("rst_mid_seq", req_seq_num_o, 0);
        check("rst_mid_cnt", req_msg_cnt_o, 0);
        nreset = 1'b1;
        repeat (15) tick();
        check("rst_fifo_empty", req_v_o, 1'b0);
        push(80'd40, 64'd7, 64'd3, 1'b0);
        wait_drain(100, "post_rst_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
